// File: rtl/riscv_pkg.sv
// Shared front-end definitions used by fetch and decode.
package riscv_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int INST_WIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [INST_WIDTH_DEF-1:0] instr;
        logic [XLEN_DEF-1:0]       pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {instr, pc} entries; head is read combinationally.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_pop_s;
    logic             do_push_s;

    // A pop frees a slot, so a full queue may still take a push in the same cycle
    always_comb begin
        do_pop_s  = pop && (count_r != CW'(0));
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (clear) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) mem_r[wr_ptr_r] <= push_data;
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));

endmodule

// File: rtl/fetch_stage_chk.sv
// Invariant checks for the fetch stage credit and response accounting.
module fetch_stage_chk #(
    parameter int FQ_DEPTH = 4,
    parameter int CW       = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          resp_valid,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] q_count,
    input logic          q_full,
    input logic          push,
    input logic          pop
);

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(resp_valid && (inflight == CW'(0))));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, q_count} + {1'b0, inflight}) <= (CW+1)'(FQ_DEPTH)));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && q_full && !pop));

endmodule

// File: rtl/fetch_stage.sv
// In-order fetch: credit-limited request issue, in-order response capture, flush with stale-response drop.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              INST_WIDTH = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEF),
    parameter int              FQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic                  stall,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [XLEN-1:0]       imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    output logic [INST_WIDTH-1:0] instr_out,
    output logic [XLEN-1:0]       pc_out,
    output logic                  valid_out
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam int EW = INST_WIDTH + XLEN;

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] resp_pc_r;
    logic [CW-1:0]   inflight_r;
    logic [CW-1:0]   drop_cnt_r;
    logic [CW-1:0]   q_count_s;
    logic [CW-1:0]   inflight_after_resp_s;
    logic [CW:0]     credit_used_s;
    logic [EW-1:0]   head_s;
    logic            q_full_s;
    logic            q_empty_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            drop_s;
    logic            push_s;
    logic            pop_s;

    // Credit, handshake and queue control decisions for this cycle
    always_comb begin
        credit_used_s = {1'b0, q_count_s} + {1'b0, inflight_r};
        req_valid_s   = !rst && !flush && (credit_used_s < (CW+1)'(FQ_DEPTH));
        req_fire_s    = req_valid_s && imem_req_ready;
        drop_s        = imem_resp_valid && (drop_cnt_r != CW'(0));
        push_s        = imem_resp_valid && !drop_s && !flush;
        pop_s         = !q_empty_s && !stall && !flush;
        if (imem_resp_valid && (inflight_r != CW'(0))) begin
            inflight_after_resp_s = inflight_r - CW'(1);
        end else begin
            inflight_after_resp_s = inflight_r;
        end
    end

    // PC and outstanding-request tracking; a flush marks everything still in flight as stale
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            inflight_r <= CW'(0);
            drop_cnt_r <= CW'(0);
        end else if (flush) begin
            fetch_pc_r <= redirect_pc;
            resp_pc_r  <= redirect_pc;
            inflight_r <= inflight_after_resp_s;
            drop_cnt_r <= inflight_after_resp_s;
        end else begin
            if (req_fire_s) fetch_pc_r <= fetch_pc_r + XLEN'(4);
            if (push_s)     resp_pc_r  <= resp_pc_r + XLEN'(4);
            if (drop_s)     drop_cnt_r <= drop_cnt_r - CW'(1);
            inflight_r <= inflight_after_resp_s + CW'(req_fire_s);
        end
    end

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (EW)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push_s),
        .push_data ({imem_resp_data, resp_pc_r}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (q_count_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    fetch_stage_chk #(
        .FQ_DEPTH (FQ_DEPTH),
        .CW       (CW)
    ) u_chk (
        .clk        (clk),
        .rst        (rst),
        .resp_valid (imem_resp_valid),
        .inflight   (inflight_r),
        .q_count    (q_count_s),
        .q_full     (q_full_s),
        .push       (push_s),
        .pop        (pop_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_r;
    assign valid_out      = !q_empty_s;
    assign instr_out      = q_empty_s ? INST_WIDTH'(0) : head_s[EW-1:XLEN];
    // With nothing queued, pc_out shows the PC the next response will carry
    assign pc_out         = q_empty_s ? resp_pc_r : head_s[XLEN-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a request/response-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_out       (instr_out),
        .pc_out          (pc_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        outq[$];
    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT with the model, advance the model across the edge
    task automatic step(input bit fl, input logic [31:0] rpc, input bit st, input bit rdy, input int lat);
        bit   exp_rv;
        bit   fire;
        bit   rsp;
        req_t r;
        @(negedge clk);
        flush          = fl;
        redirect_pc    = rpc;
        stall          = st;
        imem_req_ready = rdy;
        rsp            = (outq.size() > 0) && (outq[0].due <= cyc);
        imem_resp_valid = rsp;
        imem_resp_data  = rsp ? mem_word(outq[0].addr) : 32'h0;
        #1;
        exp_rv = !fl && ((mq.size() + outq.size()) < 4);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("valid_out", 32'(valid_out), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("pc_out", pc_out, mq[0].pc);
            chk("instr_out", instr_out, mq[0].instr);
        end
        fire = exp_rv && rdy;
        if (!fl && (mq.size() > 0) && !st) void'(mq.pop_front());
        if (rsp) begin
            r = outq.pop_front();
            if (!r.stale) mq.push_back('{r.addr, mem_word(r.addr)});
        end
        if (fl) begin
            mq.delete();
            foreach (outq[i]) outq[i].stale = 1'b1;
            m_pc = rpc;
        end else if (fire) begin
            outq.push_back('{m_pc, cyc + 1 + lat, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        flush           = 1'b0;
        stall           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);
        mq.delete();
        outq.delete();
        m_pc = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_first(input string nm, input logic [31:0] pc, input logic [31:0] ins);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1, 0);
            if (valid_out) begin
                seen = 1'b1;
                chk({nm, "_pc"}, pc_out, pc);
                chk({nm, "_instr"}, instr_out, ins);
            end
        end
        if (!seen) chk({nm, "_timeout"}, 32'(seen), 32'h1);
    endtask

    bit          r_fl;
    bit          r_st;
    bit          r_rdy;
    logic [31:0] r_pc;

    initial begin
        do_reset();

        // Back-to-back issue with single-cycle memory
        step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        chk("t1_addr0", imem_req_addr, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        chk("t1_addr1", imem_req_addr, 32'h4);
        step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        chk("t1_pc0", pc_out, 32'h0);
        chk("t1_instr0", instr_out, 32'h0000_FFFF);
        step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        chk("t1_pc1", pc_out, 32'h4);
        chk("t1_instr1", instr_out, 32'h0004_FFFB);
        step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        chk("t1_pc2", pc_out, 32'h8);
        chk("t1_instr2", instr_out, 32'h0008_FFF7);

        // Decode stall fills the credit window, then drains in order
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1, 0);
        chk("stall_no_req", 32'(imem_req_valid), 32'h0);
        chk("stall_valid", 32'(valid_out), 32'h1);
        chk("stall_pc_frozen", pc_out, 32'hC);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 0);
            chk("drain_pc", pc_out, 32'hC + 32'(4 * k));
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 0);
        chk("drain_empty", 32'(valid_out), 32'h0);

        // Flush with three requests in flight
        do_reset();
        step(1'b1, 32'h10, 1'b0, 1'b0, 0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 3);
        chk("fl_addr10", imem_req_addr, 32'h10);
        step(1'b0, 32'h0, 1'b0, 1'b1, 3);
        step(1'b0, 32'h0, 1'b0, 1'b1, 3);
        chk("fl_addr18", imem_req_addr, 32'h18);
        step(1'b1, 32'h100, 1'b0, 1'b1, 0);
        expect_first("fl_first", 32'h100, 32'h0100_FEFF);

        // Flush coinciding with a response
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        step(1'b1, 32'h200, 1'b1, 1'b1, 0);
        expect_first("flr_first", 32'h200, 32'h0200_FDFF);

        // Random ready, latency, stall and flush traffic
        for (int i = 0; i < 3000; i++) begin
            r_fl  = ($urandom_range(0, 99) < 4);
            r_st  = ($urandom_range(0, 99) < 30);
            r_rdy = ($urandom_range(0, 1) == 1);
            r_pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 255)) << 2);
            step(r_fl, r_pc, r_st, r_rdy, int'($urandom_range(0, 3)));
        end

        // Asynchronous reset in the middle of a burst
        do_reset();
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        repeat (2) step(1'b0, 32'h0, 1'b1, 1'b1, 3);
        chk("pre_reset_valid", 32'(valid_out), 32'h1);
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1, 0);
        chk("restart_addr", imem_req_addr, 32'h0);
        repeat (20) step(1'b0, 32'h0, 1'b0, 1'b1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
